// File: rtl/spi_flash_responder.sv
// spi_flash_responder: oversampled SPI mode 0 flash model answering READ, READ ID and READ STATUS from a byte memory port
module spi_flash_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spi_sck_i,
  input  logic                  spi_csb_i,
  input  logic                  spi_sd0_i,
  output logic                  spi_sd1_o,
  output logic                  spi_sd1_oe_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [7:0]            mem_rdata_i,
  output logic [7:0]            cmd_o,
  output logic                  cmd_valid_o,
  output logic                  busy_o
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, STATUS, IGNORE} state_e;
  state_e state_q;
  logic [2:0] sck_q, csb_q, sd0_q;
  logic rise_q, fall_q, csb_rise_q, csb_fall_q, live_q, armed_q;
  logic [4:0] cnt_q;
  logic [ADDR_WIDTH-2:0] sh_q;
  logic [ADDR_WIDTH-1:0] sh_d, addr_q;
  logic [7:0] tx_q, pref_q, cmd_q, byte_d;
  logic [1:0] idx_q;
  logic sd1_q, oe_q, req_q, pend_q, cmd_valid_q;
  always_comb begin
    sh_d = {sh_q, sd0_q[2]};
    byte_d = state_q == DATA ? pref_q :
             state_q == STATUS ? 8'h00 :
             idx_q == 2'd0 ? JEDEC_ID[23:16] :
             idx_q == 2'd1 ? JEDEC_ID[15:8] :
             idx_q == 2'd2 ? JEDEC_ID[7:0] : 8'h00;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sck_q <= 3'b000;
      csb_q <= 3'b111;
      sd0_q <= 3'b000;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      csb_rise_q <= 1'b0;
      csb_fall_q <= 1'b0;
      live_q <= 1'b0;
      armed_q <= 1'b0;
      cnt_q <= '0;
      sh_q <= '0;
      addr_q <= '0;
      tx_q <= '0;
      pref_q <= '0;
      cmd_q <= '0;
      idx_q <= '0;
      sd1_q <= 1'b0;
      oe_q <= 1'b0;
      req_q <= 1'b0;
      pend_q <= 1'b0;
      cmd_valid_q <= 1'b0;
    end else begin
      sck_q <= {sck_q[1:0], spi_sck_i};
      csb_q <= {csb_q[1:0], spi_csb_i};
      sd0_q <= {sd0_q[1:0], spi_sd0_i};
      rise_q <= sck_q[1] & ~sck_q[2];
      fall_q <= ~sck_q[1] & sck_q[2];
      csb_rise_q <= csb_q[1] & ~csb_q[2];
      csb_fall_q <= ~csb_q[1] & csb_q[2];
      live_q <= 1'b1;
      armed_q <= armed_q | (live_q & csb_q[0]);
      cmd_valid_q <= 1'b0;
      req_q <= 1'b0;
      pend_q <= req_q;
      if (pend_q) pref_q <= mem_rdata_i;
      if (csb_rise_q) begin
        state_q <= IDLE;
        oe_q <= 1'b0;
        sd1_q <= 1'b0;
        pend_q <= 1'b0;
      end else if (state_q == IDLE) begin
        if (csb_fall_q && armed_q) begin
          state_q <= CMD;
          cnt_q <= '0;
        end
      end else if (rise_q && (state_q == CMD || state_q == ADDR)) begin
        sh_q <= sh_d[ADDR_WIDTH-2:0];
        cnt_q <= cnt_q + 5'd1;
        if (state_q == CMD && cnt_q == 5'd7) begin
          cmd_q <= sh_d[7:0];
          cmd_valid_q <= 1'b1;
          cnt_q <= '0;
          idx_q <= '0;
          state_q <= sh_d[7:0] == 8'h03 ? ADDR :
                     sh_d[7:0] == 8'h9F ? ID :
                     sh_d[7:0] == 8'h05 ? STATUS : IGNORE;
        end
        if (state_q == ADDR && cnt_q == 5'd23) begin
          addr_q <= sh_d;
          req_q <= 1'b1;
          cnt_q <= '0;
          state_q <= DATA;
        end
      end else if (fall_q && (state_q == DATA || state_q == ID || state_q == STATUS)) begin
        cnt_q <= cnt_q == 5'd7 ? 5'd0 : cnt_q + 5'd1;
        oe_q <= 1'b1;
        if (cnt_q == 5'd0) begin
          sd1_q <= byte_d[7];
          tx_q <= {byte_d[6:0], 1'b0};
          idx_q <= idx_q == 2'd3 ? 2'd3 : idx_q + 2'd1;
          if (state_q == DATA) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            req_q <= 1'b1;
          end
        end else begin
          sd1_q <= tx_q[7];
          tx_q <= {tx_q[6:0], 1'b0};
        end
      end
    end
  end
  assign spi_sd1_o = sd1_q;
  assign spi_sd1_oe_o = oe_q;
  assign mem_req_o = req_q;
  assign mem_addr_o = addr_q;
  assign cmd_o = cmd_q;
  assign cmd_valid_o = cmd_valid_q;
  assign busy_o = ~csb_q[2];
endmodule
